// File: rtl/scr1_sha256_pkg.sv
// Shared SHA-256 definitions for the SCR1 accelerator: block geometry,
// message-schedule FSM states and the small-sigma functions.
package scr1_sha256_pkg;

  localparam int SHA256_WORDS_PER_BLK = 16;
  localparam int SHA256_ROUNDS        = 64;

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } type_scr1_sha256_sched_st_e;

  // sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
  function automatic logic [31:0] sha256_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
  function automatic logic [31:0] sha256_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/scr1_sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 message words into a 16-slot circular
// window, then streams W0..W[NUM_ROUNDS-1] to the round engine.
//
// Handshakes: a word moves on a rising clk edge where valid & ready are both
// high. valid never depends on ready; while valid is high and ready is low
// the producer holds data/round stable. clr overrides both handshakes.
module scr1_sha256_msg_sched
  import scr1_sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = SHA256_ROUNDS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       blk_valid,
  input  logic [31:0]                blk_word,
  output logic                       blk_ready,
  output logic                       w_valid,
  output logic [31:0]                w_data,
  output logic [5:0]                 w_round,
  input  logic                       w_ready,
  output logic                       busy,
  output logic                       done,
  output type_scr1_sha256_sched_st_e dbg_state
);

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);
  localparam logic [3:0] LAST_CNT = 4'(SHA256_WORDS_PER_BLK - 1);

  type_scr1_sha256_sched_st_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] slot_q [16];
  logic [31:0] slot_d [16];
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [3:0]  t4;
  logic [3:0]  idx_m2;
  logic [3:0]  idx_m7;
  logic [3:0]  idx_m15;
  logic [31:0] sched_word;
  logic        blk_hs;
  logic        w_hs;

  // Schedule-word adder tree; the window slots wrap with 4-bit index math.
  always_comb begin
    t4         = t_q[3:0];
    idx_m2     = t4 - 4'd2;
    idx_m7     = t4 - 4'd7;
    idx_m15    = t4 - 4'd15;
    sched_word = sha256_sigma1(slot_q[idx_m2]) + slot_q[idx_m7]
               + sha256_sigma0(slot_q[idx_m15]) + slot_q[t4];
    w_data     = (t_q < 6'd16) ? slot_q[t4] : sched_word;
  end

  assign blk_ready = (state_q == LOAD);
  assign w_valid   = (state_q == STREAM);
  assign w_round   = t_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;
  assign blk_hs    = blk_valid & blk_ready;
  assign w_hs      = w_valid & w_ready;

  // Next-state logic: load counting, streaming and window write-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    slot_d  = slot_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (clr) begin
      state_d = LOAD;
      cnt_d   = 4'd0;
      t_d     = 6'd0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (blk_hs) begin
            slot_d[cnt_q] = blk_word;
            cnt_d         = cnt_q + 4'd1;
            busy_d        = 1'b1;
            if (cnt_q == LAST_CNT) begin
              state_d = STREAM;
              t_d     = 6'd0;
              cnt_d   = 4'd0;
            end
          end
        end
        STREAM: begin
          if (w_hs) begin
            // For t<16 this rewrites the value already held in the slot.
            slot_d[t4] = w_data;
            if (t_q == LAST_T) begin
              state_d = LOAD;
              t_d     = 6'd0;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              t_d = t_q + 6'd1;
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  // State, counters and window registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= 4'd0;
      t_q     <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) slot_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < 16; i++) slot_q[i] <= slot_d[i];
    end
  end

endmodule

// File: tb/tb_scr1_sha256_msg_sched.sv
// Bench for the SHA-256 message schedule: random and known blocks, random
// backpressure, input gaps, abort and back-to-back blocks.
module tb_scr1_sha256_msg_sched;
  import scr1_sha256_pkg::*;

  typedef logic [31:0] blk_t [16];

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        blk_valid;
  logic [31:0] blk_word;
  logic        blk_ready;
  logic        w_valid;
  logic [31:0] w_data;
  logic [5:0]  w_round;
  logic        w_ready;
  logic        busy;
  logic        done;
  type_scr1_sha256_sched_st_e dbg_state;

  int          n_checks;
  int          n_fails;
  logic [31:0] exp_q[$];
  logic [5:0]  exp_r_q[$];
  logic [31:0] obs_w [64];
  logic        exp_done;
  int          done_cnt;
  bit          mon_en;
  int          ready_mode;
  int          stall_left;

  scr1_sha256_msg_sched #(.NUM_ROUNDS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .blk_valid (blk_valid),
    .blk_word  (blk_word),
    .blk_ready (blk_ready),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_round   (w_round),
    .w_ready   (w_ready),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model helpers: straight FIPS 180-4 arithmetic on a 64-entry array.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // w_ready driver: always-ready or random, with an optional forced stall at t=20.
  initial begin
    w_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) w_ready = 1'b1;
      else                 w_ready = 1'($urandom_range(0, 1));
      if (stall_left > 0 && w_valid && w_round == 6'd20) begin
        w_ready    = 1'b0;
        stall_left = stall_left - 1;
      end
    end
  end

  // Scoreboard: every valid cycle must present the front expected word.
  initial begin
    logic nd;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("done_pulse", done, exp_done);
        if (w_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_w_valid", w_valid, 1'b0);
          end else begin
            chk("w_data", w_data, exp_q[0]);
            chk("w_round", w_round, exp_r_q[0]);
          end
        end
        nd = 1'b0;
        if (clr) begin
          exp_q.delete();
          exp_r_q.delete();
        end else if (w_valid && w_ready && exp_q.size() > 0) begin
          obs_w[exp_r_q[0]] = w_data;
          if (exp_r_q[0] == 6'd63) begin
            nd = 1'b1;
            done_cnt++;
          end
          void'(exp_q.pop_front());
          void'(exp_r_q.pop_front());
        end
        exp_done = nd;
      end
    end
  end

  task automatic push_word(input logic [31:0] w, input bit chk_done);
    int n;
    n = 0;
    blk_valid = 1'b1;
    blk_word  = w;
    forever begin
      @(negedge clk);
      if (blk_ready || n >= 1000) break;
      n++;
    end
    if (!blk_ready) chk("blk_ready_timeout", 32'(blk_ready), 32'd1);
    else if (chk_done) chk("b2b_load_in_done_cycle", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
  endtask

  task automatic push_block(input blk_t m, input int gap_after, input int gap_len, input bit b2b);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++)
      w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      exp_q.push_back(w[t]);
      exp_r_q.push_back(6'(t));
    end
    for (int i = 0; i < 16; i++) begin
      push_word(m[i], b2b && (i == 0));
      if (i == gap_after) begin
        repeat (gap_len) begin
          @(negedge clk);
          chk("gap_no_w_valid", w_valid, 1'b0);
          chk("gap_blk_ready", blk_ready, 1'b1);
          chk("gap_busy", busy, 1'b1);
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic blk_t rand_blk();
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = $urandom;
    return b;
  endfunction

  // Test sequence
  initial begin
    blk_t abc;
    blk_t b1;
    blk_t b2;
    int   n;
    int   d0;

    n_checks = 0; n_fails = 0; done_cnt = 0; exp_done = 1'b0;
    mon_en = 1'b0; ready_mode = 0; stall_left = 0;
    rst_n = 1'b0; clr = 1'b0; blk_valid = 1'b0; blk_word = 32'd0;
    for (int i = 0; i < 16; i++) abc[i] = 32'd0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_blk_ready", blk_ready, 1'b1);
    chk("rst_w_valid", w_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_w_round", w_round, 6'd0);
    chk("rst_w_data", w_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // "abc" block, no backpressure
    push_block(abc, -1, 0, 1'b0);
    @(negedge clk);
    chk("abc_w0_latency_valid", w_valid, 1'b1);
    chk("abc_w0_latency_round", w_round, 6'd0);
    chk("abc_busy_stream", busy, 1'b1);
    wait_idle();
    chk("abc_w16", obs_w[16], 32'h61626380);
    chk("abc_w17", obs_w[17], 32'h000F0000);
    chk("abc_done_count", done_cnt, 32'd1);
    chk("abc_busy_after", busy, 1'b0);
    chk("abc_ready_after", blk_ready, 1'b1);

    // Same block under random backpressure plus a 5-cycle stall at t=20
    ready_mode = 1;
    stall_left = 5;
    push_block(abc, -1, 0, 1'b0);
    wait_idle();
    chk("stall_applied", stall_left, 32'd0);
    chk("bp_w17", obs_w[17], 32'h000F0000);
    chk("bp_done_count", done_cnt, 32'd2);

    // Input gap of 3 cycles between M7 and M8
    ready_mode = 0;
    push_block(rand_blk(), 7, 3, 1'b0);
    wait_idle();
    chk("gap_done_count", done_cnt, 32'd3);

    // Abort at t=30
    push_block(rand_blk(), -1, 0, 1'b0);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if ((w_valid && w_round == 6'd30) || n >= 200) break;
      n++;
    end
    chk("clr_reached_t30", w_round, 6'd30);
    d0  = done_cnt;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_w_valid", w_valid, 1'b0);
    chk("clr_blk_ready", blk_ready, 1'b1);
    chk("clr_done", done, 1'b0);
    chk("clr_busy", busy, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("clr_no_done", done_cnt, 32'(d0));
    push_block(rand_blk(), -1, 0, 1'b0);
    wait_idle();
    chk("post_clr_done_count", done_cnt, 32'(d0 + 1));

    // Back-to-back blocks with random backpressure; second loads in done cycle
    ready_mode = 1;
    d0 = done_cnt;
    b1 = rand_blk();
    b2 = rand_blk();
    push_block(b1, -1, 0, 1'b0);
    push_block(b2, -1, 0, 1'b1);
    wait_idle();
    chk("b2b_done_count", done_cnt, 32'(d0 + 2));
    chk("b2b_queue_empty", exp_q.size(), 32'd0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/scr1_sha256_msg_sched.md
Name: scr1_sha256_msg_sched

Overview:
SHA-256 message-schedule stage feeding the SHA-256 round/compression engine in the SCR1 accelerator subsystem. It accepts one 512-bit block as 16 big-endian 32-bit words pushed by the accelerator's memory-mapped register front end. It then streams the 64 schedule words W0..W63, one per handshake, to the round engine. A 16-entry circular buffer holds the sliding window needed for W16..W63.

Parameters:
NUM_ROUNDS, 64, number of W words emitted per block; legal range 16..64, tests use 64.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clr  in  1  synchronous abort; drops the current block
blk_valid  in  1  input word valid
blk_word  in  32  message word M[i], big-endian as in FIPS 180-4
blk_ready  out  1  stage can accept a message word
w_valid  out  1  schedule word valid
w_data  out  32  schedule word W[t]
w_round  out  6  round index t of w_data
w_ready  in  1  round engine accepts W[t]
busy  out  1  high from the first accepted word until the last W is accepted
done  out  1  one-cycle pulse after W[NUM_ROUNDS-1] is accepted

Behaviour:
- Clock and reset: clk, with rst_n asynchronous and active-low.
- Reset values: state LOAD; load count 0; t 0; buffer all 0; blk_ready=1; w_valid=0; w_round=0; busy=0; done=0. w_data equals buffer slot 0, which is 0.
- FSM states: LOAD and STREAM.
- LOAD:
  - blk_ready=1 and w_valid=0.
  - On blk_valid & blk_ready, write blk_word into slot[cnt] and increment cnt.
  - After the 16th accepted word (cnt==15 plus handshake): next state STREAM, t=0, cnt=0.
- STREAM:
  - blk_ready=0 and w_valid=1.
  - w_round=t.
  - For t<16: w_data = slot[t].
  - For t>=16: w_data = sigma1(slot[(t-2)%16]) + slot[(t-7)%16] + sigma0(slot[(t-15)%16]) + slot[t%16], modulo 2^32.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3. sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - On w_valid & w_ready: write w_data into slot[t%16] (a no-op rewrite for t<16), then t++.
  - On the handshake at t==NUM_ROUNDS-1: next state LOAD, t=0, done=1 for exactly one cycle.
- Latency: W0 is valid in the cycle after the 16th word handshake. Throughput is 1 W per cycle while w_ready=1. A new block may begin loading in the cycle done is high.
- Backpressure: while w_valid & !w_ready, w_data and w_round hold stable because the buffer and t are unchanged.
- busy: high from the cycle after the first LOAD handshake until the cycle after the final STREAM handshake.
- clr:
  - Priority over all handshakes.
  - Next cycle: state LOAD, cnt=0, t=0, busy=0, done=0.
  - Buffer contents are don't-care.
  - No W is emitted for the aborted block.
- Reset mid-operation: immediately forces the reset values above, in either state.
- blk_valid while in STREAM is ignored (blk_ready=0). w_ready while in LOAD is ignored.
- All index arithmetic is 4-bit modulo-16, with natural wrap.

Decomposition:
- Package scr1_sha256_pkg holds:
  - SHA256_WORDS_PER_BLK=16 and SHA256_ROUNDS=64
  - enum type_scr1_sha256_sched_st_e {LOAD, STREAM}
  - functions sha256_sigma0 and sha256_sigma1 (the K constants are added here later for the round engine)
- No sub-module. The adder tree is a single always_comb inside this module.

Test Plan:
- Reset: rst_n low, then high -> blk_ready=1, w_valid=0, busy=0, done=0.
- "abc" block: M0=0x61626380, M1..M14=0, M15=0x00000018, w_ready=1.
  - W0 is valid 1 cycle after M15 is accepted.
  - W16=0x61626380 and W17=0x000F0000.
  - All 64 words match the C reference model.
  - done pulses once.
- Backpressure: same block, w_ready toggled randomly, including a 5-cycle stall at t=20 -> w_data and w_round hold during the stall, and the sequence is identical to the unstalled run.
- Input gaps: blk_valid deasserted for 3 cycles between M7 and M8 -> no W is emitted until after M15, and the output is correct.
- clr at t=30 -> next cycle w_valid=0, blk_ready=1, no done pulse. Then a second full block gives the correct W stream.
- Back-to-back blocks: the second block is pushed starting in the done cycle -> no dropped words, and the second W stream is correct.
